// File: rtl/mdu_pkg.sv
// Shared encodings for the multicycle multiply/divide unit: operation codes,
// FSM states and small op-decoding helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the CPU controller (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (output start, op, a, b,
                    input  hi, lo, busy, done, div_zero);
    modport slave  (input  start, op, a, b,
                    output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mdu_iter_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH+1 state.
// Multiply layout: {0, hi, lo/multiplier}. Divide layout: {rem(W+1), dividend/quotient}.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  opnd_i,
    input  logic              div_i,
    output logic [2*WIDTH:0]  acc_o
);
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        mul_sum = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : '0);
        part    = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = part - {1'b0, opnd_i};
        ge      = (part >= {1'b0, opnd_i});
        if (div_i) begin
            // Partial remainder stays below the divisor, so its top bit is always 0.
            acc_o = {(ge ? diff : part), acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit owning HI/LO; WIDTH+2 cycle latency,
// divide-by-zero completes in one cycle with HI/LO untouched.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_d;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             div_q, neg_quo_q, neg_rem_q;
    logic             busy_q, done_q, dz_q;

    logic             in_div, in_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign in_div    = op_is_div(bus.op);
    assign in_signed = op_is_signed(bus.op);

    // Magnitudes in WIDTH bits unsigned keep |MIN| = 2^(WIDTH-1) exact.
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        if (in_signed && bus.a[WIDTH-1]) a_mag = -bus.a;
        if (in_signed && bus.b[WIDTH-1]) b_mag = -bus.b;
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (acc_d)
    );

    always_comb begin
        prod = acc_q[2*WIDTH-1:0];
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (neg_quo_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (neg_rem_q) rem = -rem;
        hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = div_q ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (in_div && (bus.b == '0)) begin
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            acc_q     <= {{(WIDTH+1){1'b0}}, a_mag};
                            opnd_q    <= b_mag;
                            div_q     <= in_div;
                            neg_quo_q <= in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_q <= in_signed & bus.a[WIDTH-1];
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    dz_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit (WIDTH=32) against a plain-arithmetic model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {hi, lo} from 64-bit integer arithmetic; divide by zero leaves the old pair.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = prev;
        if (op == OP_MULTU)               r = ua * ub;
        else if (op == OP_MULT)           r = sa * sb;
        else if (op == OP_DIVU && b != 0) r = {32'(ua % ub), 32'(ua / ub)};
        else if (op == OP_DIV && b != 0)  r = {32'(sa % sb), 32'(sa / sb)};
        return r;
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
        int          n;
        int          busy_cnt;
        logic [63:0] exp;
        logic        dz_exp;
        exp    = model(op, a, b, {prev_hi, prev_lo});
        dz_exp = op_is_div(op) && (b == 0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (poke && n == 3) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'hFFFF_FFFF;
                bus.b     = 32'hFFFF_FFFF;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(n), dz_exp ? 64'd1 : 64'd34);
        check({tag, " busy_cycles"}, 64'(busy_cnt), dz_exp ? 64'd0 : 64'd33);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(dz_exp));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
        @(posedge clock); #1;
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, " dz_pulse"}, 64'(bus.div_zero), 64'd0);
        check({tag, " idle_after"}, 64'(bus.busy), 64'd0);
        check({tag, " hi_hold"}, 64'(bus.hi), 64'(prev_hi));
    endtask

    initial begin
        int          done_seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dz", 64'(bus.div_zero), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 1'b0);
        do_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("preset", OP_MULTU, 32'h6666_6666, 32'h2AAA_AAAB, 1'b0);
        do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1'b0);
        do_op("div_zero_s", OP_DIV, 32'h8000_0000, 32'd0, 1'b0);
        do_op("poke_busy", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            do_op("random", rop, ra, rb, 1'b0);
        end

        do_op("pre_reset", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h9ABC_DEF0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midop hi", 64'(bus.hi), 64'd0);
        check("midop lo", 64'(bus.lo), 64'd0);
        check("midop busy", 64'(bus.busy), 64'd0);
        check("midop done", 64'(bus.done), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        done_seen = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        check("midop no_done", 64'(done_seen), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        do_op("after_reset", OP_DIVU, 32'd100, 32'd7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
